score_window_sequencer: RTL and testbench
=========================================

Name: score_window_sequencer

Overview:
Parametrised successor to the fixed 4-song, 16-note score loader. It reads a song from an external synchronous score ROM, presents a sliding look-ahead window of upcoming notes to the video/game logic, and generates the beat strobe from a run-time tempo. Over the fixed loader it adds:
- start/pause control
- explicit end-of-song drain
- address-overflow protection
- a beat counter for scoring

Parameters:
NOTE_W, 4, bits per note code
WINDOW, 16, notes visible in the look-ahead window (min 2)
ADDR_W, 8, note address bits per song
SONG_W, 2, song select bits (2**SONG_W songs)
TEMPO_W, 26, width of tempo period (clock cycles per beat)
REST_CODE, 0, note code shifted in as padding
END_CODE, all-ones, note code marking end of song

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
song_sel  in  SONG_W  song to play, sampled on start
tempo_cycles  in  TEMPO_W  beat period in clk cycles, sampled on start
start  in  1  one-cycle pulse; begins playback from IDLE or DONE
pause  in  1  level; freezes tempo counter and shifting while high
rom_addr  out  SONG_W+ADDR_W  {song, note address} to score ROM
rom_data  in  NOTE_W  ROM output, valid 1 cycle after rom_addr changes
window_out  out  NOTE_W*WINDOW  slot 0 in LSBs (current note), slot WINDOW-1 in MSBs (furthest ahead)
beat  out  1  one-cycle pulse on every shift
busy  out  1  high in PREFETCH, PLAY, DRAIN
song_done  out  1  high while window slot 0 == END_CODE
beat_count  out  16  beats since start, saturating at 16'hFFFF

Behaviour:
- Reset values:
  - state IDLE
  - all window slots REST_CODE
  - rom_addr 0
  - beat, busy, song_done 0
  - beat_count 0
  - tempo counter 0
- Tempo latch: latched period = max(tempo_cycles, 4). Values 0..3 clamp to 4.
- IDLE / DONE:
  - start=1 → latch song_sel and tempo; clear window to REST_CODE; note address 0; beat_count 0; go to PREFETCH.
  - start is ignored in every other state.
- PREFETCH: wait 2 cycles so that rom_data for address 0 is captured into next_note; then go to PLAY with tempo counter 0.
- PLAY, tempo counter:
  - Counter increments each cycle when pause=0.
  - At count == period-1: counter returns to 0 and beat pulses that cycle.
  - The first beat occurs exactly `period` unpaused cycles after entering PLAY.
- PLAY, on beat:
  - slot[i] <= slot[i+1]; slot[WINDOW-1] <= next_note.
  - beat_count increments.
  - If next_note != END_CODE: note address increments and next_note is refreshed 2 cycles later; the period is at least 4, so the refresh always lands before the next beat.
  - If next_note == END_CODE: address frozen, go to DRAIN.
- Address overflow: if the note address is 2**ADDR_W-1 and its note is not END_CODE, the next note loaded is forced to END_CODE. The song never wraps into another song's space.
- DRAIN:
  - Beats continue; REST_CODE is shifted into slot WINDOW-1.
  - When the END_CODE entry reaches slot 0 (song_done rises on that beat's edge), go to DONE.
- DONE:
  - busy=0, beat=0, window held; song_done stays high.
  - start → IDLE-style restart.
- pause:
  - Tempo counter, shifting and beat are all frozen while pause=1; counting resumes from the held count.
  - pause is ignored in IDLE, PREFETCH and DONE.
- Reset mid-operation: returns to the reset state on the next edge; the outstanding ROM read is discarded.
- start and pause in the same cycle in IDLE: start wins. Playback enters PREFETCH, and pause then holds the PLAY counter.

Optional Feature:
Macro SCORE_LOOP_EN.
- Defined:
  - Adds input `loop` (1 bit, level) and output `loop_count` (8 bits, reset 0, wraps at 255).
  - If loop=1 on a beat where next_note == END_CODE: END_CODE is not shifted in; slot WINDOW-1 receives REST_CODE; address returns to 0; loop_count increments; state stays PLAY.
  - Address overflow with loop=1 behaves the same way.
- Not defined: ports absent; END_CODE always ends the song as described above.

Test Plan:
- Reset, then start with song_sel=2, tempo_cycles=10 → rom_addr=0x200; first beat 2+10 cycles after start; slot 15 = ROM[0x200] after beat 1; beat period 10.
- Song ROM 1,2,3,END; WINDOW=16; tempo 5 → beats 1..3 load 1,2,3; beat 4 loads END; slot0==END after beat 19; song_done=1; busy=0; beat_count=19.
- tempo_cycles=1 → beats every 4 cycles (clamp).
- Hold pause for 7 cycles mid-period with tempo 8 → next beat delayed by exactly 7 cycles; window unchanged during pause.
- Song with no END_CODE, ADDR_W=3 → END forced after address 7; rom_addr never exceeds {song,3'b111}.
- Assert reset mid-DRAIN → next cycle window all REST_CODE, state IDLE, beat_count 0. With SCORE_LOOP_EN and loop=1, ROM 1,END → window sequence 1,REST,1,REST…; loop_count increments every 2 beats.

Source files
------------

// File: rtl/score_window_sequencer.sv
// score_window_sequencer: streams a song from a synchronous score ROM into a look-ahead
// note window and emits tempo-driven beats. Optional song looping: define SCORE_LOOP_EN.
module score_window_sequencer #(
  parameter int                NOTE_W    = 4,
  parameter int                WINDOW    = 16,
  parameter int                ADDR_W    = 8,
  parameter int                SONG_W    = 2,
  parameter int                TEMPO_W   = 26,
  parameter logic [NOTE_W-1:0] REST_CODE = '0,
  parameter logic [NOTE_W-1:0] END_CODE  = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SONG_W-1:0]        song_sel,
  input  logic [TEMPO_W-1:0]       tempo_cycles,
  input  logic                     start,
  input  logic                     pause,
`ifdef SCORE_LOOP_EN
  input  logic                     loop,
  output logic [7:0]               loop_count,
`endif
  output logic [SONG_W+ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0]        rom_data,
  output logic [NOTE_W*WINDOW-1:0] window_out,
  output logic                     beat,
  output logic                     busy,
  output logic                     song_done,
  output logic [15:0]              beat_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_PLAY,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [TEMPO_W-1:0] MIN_PERIOD = TEMPO_W'(4);
  localparam logic [WINDOW-1:0][NOTE_W-1:0] REST_WINDOW = {WINDOW{REST_CODE}};

  state_t                         state;
  logic [SONG_W-1:0]              song_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [TEMPO_W-1:0]             period_q;
  logic [TEMPO_W-1:0]             tempo_cnt;
  logic [NOTE_W-1:0]              next_note;
  logic [1:0]                     fetch_pipe;
  logic [WINDOW-1:0][NOTE_W-1:0]  window_q;
  logic                           beat_tick;

  // fetch_pipe[1] marks the cycle in which rom_data holds the note for addr_q.
  assign beat_tick = (state == S_PLAY || state == S_DRAIN) && !pause &&
                     (tempo_cnt == period_q - TEMPO_W'(1));

  assign rom_addr   = {song_q, addr_q};
  assign window_out = window_q;
  assign busy       = (state == S_PREFETCH) || (state == S_PLAY) || (state == S_DRAIN);
  assign song_done  = (window_q[0] == END_CODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      song_q     <= '0;
      addr_q     <= '0;
      period_q   <= MIN_PERIOD;
      tempo_cnt  <= '0;
      next_note  <= REST_CODE;
      fetch_pipe <= '0;
      // NOTE: the window is a set of visible flops, not a RAM, so every slot is reset.
      window_q   <= REST_WINDOW;
      beat       <= 1'b0;
      beat_count <= '0;
`ifdef SCORE_LOOP_EN
      loop_count <= '0;
`endif
    end else begin
      // NOTE: defaults first, later non-blocking assignments in this block override them.
      beat       <= 1'b0;
      fetch_pipe <= {fetch_pipe[0], 1'b0};
      if (fetch_pipe[1]) next_note <= rom_data;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            song_q     <= song_sel;
            period_q   <= (tempo_cycles < MIN_PERIOD) ? MIN_PERIOD : tempo_cycles;
            addr_q     <= '0;
            window_q   <= REST_WINDOW;
            beat_count <= '0;
            tempo_cnt  <= '0;
            fetch_pipe <= 2'b01;
            state      <= S_PREFETCH;
          end
        end

        S_PREFETCH: begin
          if (fetch_pipe[1]) begin
            tempo_cnt <= '0;
            state     <= S_PLAY;
          end
        end

        S_PLAY, S_DRAIN: begin
          if (beat_tick) begin
            tempo_cnt <= '0;
            beat      <= 1'b1;
            if (beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;

            if (state == S_DRAIN) begin
              window_q <= {REST_CODE, window_q[WINDOW-1:1]};
              if (window_q[1] == END_CODE) state <= S_DONE;
            end else if (next_note == END_CODE) begin
`ifdef SCORE_LOOP_EN
              if (loop) begin
                window_q   <= {REST_CODE, window_q[WINDOW-1:1]};
                addr_q     <= '0;
                fetch_pipe <= 2'b01;
                loop_count <= loop_count + 8'd1;
              end else begin
                window_q <= {next_note, window_q[WINDOW-1:1]};
                state    <= S_DRAIN;
              end
`else
              window_q <= {next_note, window_q[WINDOW-1:1]};
              state    <= S_DRAIN;
`endif
            end else begin
              window_q <= {next_note, window_q[WINDOW-1:1]};
              // The last address of a song never wraps into the next song's space.
              if (addr_q == '1) begin
                next_note <= END_CODE;
              end else begin
                addr_q     <= addr_q + ADDR_W'(1);
                fetch_pipe <= 2'b01;
              end
            end
          end else if (!pause) begin
            tempo_cnt <= tempo_cnt + TEMPO_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_window_sequencer.sv
// Directed testbench for score_window_sequencer: a default-size instance (ADDR_W=8,
// WINDOW=16) and a small instance (ADDR_W=3, WINDOW=4) for the address-overflow case.
module tb_score_window_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  song_sel;
  logic [25:0] tempo_cycles;
  logic        start;
  logic        pause;
`ifdef SCORE_LOOP_EN
  logic        loop;
  logic [7:0]  loop_count, loop_count2;
`endif

  logic [9:0]  rom_addr;
  logic [3:0]  rom_data;
  logic [63:0] window_out;
  logic        beat, busy, song_done;
  logic [15:0] beat_count;

  logic [4:0]  rom_addr2;
  logic [3:0]  rom_data2;
  logic [15:0] window2;
  logic        beat2, busy2, song_done2;
  logic [15:0] beat_count2;

  logic [3:0]  mem1 [1024];
  logic [3:0]  mem2 [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data  <= mem1[rom_addr];
    rom_data2 <= mem2[rom_addr2];
  end

  score_window_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .song_sel(song_sel), .tempo_cycles(tempo_cycles),
    .start(start), .pause(pause),
`ifdef SCORE_LOOP_EN
    .loop(loop), .loop_count(loop_count),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .window_out(window_out),
    .beat(beat), .busy(busy), .song_done(song_done), .beat_count(beat_count)
  );

  score_window_sequencer #(.WINDOW(4), .ADDR_W(3)) dut2 (
    .clk(clk), .reset(reset), .song_sel(song_sel), .tempo_cycles(tempo_cycles),
    .start(start), .pause(pause),
`ifdef SCORE_LOOP_EN
    .loop(loop), .loop_count(loop_count2),
`endif
    .rom_addr(rom_addr2), .rom_data(rom_data2), .window_out(window2),
    .beat(beat2), .busy(busy2), .song_done(song_done2), .beat_count(beat_count2)
  );

  task automatic do_start(input logic [1:0] s, input logic [25:0] t);
    @(negedge clk);
    song_sel = s; tempo_cycles = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Counts negedges until the selected instance shows beat; a timeout is a failure.
  task automatic wait_beat(input bit sel, input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (((sel ? beat2 : beat) !== 1'b1) && cyc < max_cyc);
    if ((sel ? beat2 : beat) !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL beat_timeout: no beat within %0d cycles (dut%0d)", max_cyc, sel ? 2 : 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; song_sel = '0; tempo_cycles = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (rom_addr !== 10'h0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
    n_tests++; if (window_out !== 64'h0) begin n_fail++; $display("FAIL reset_window: got %h want 0", window_out); end
    n_tests++; if ({beat, busy, song_done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {beat, busy, song_done}); end
    n_tests++; if (beat_count !== 16'h0) begin n_fail++; $display("FAIL reset_beat_count: got %0d want 0", beat_count); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if ({beat, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_quiet: got beat,busy=%b want 00", {beat, busy}); end
  endtask

  task automatic test_start();
    int c;
    do_start(2'd2, 26'd10);
    n_tests++; if (rom_addr !== 10'h200) begin n_fail++; $display("FAIL start_rom_addr: got %h want 200", rom_addr); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 12) begin n_fail++; $display("FAIL first_beat_latency: got %0d want 12", c); end
    n_tests++; if (window_out[63:60] !== 4'h7) begin n_fail++; $display("FAIL beat1_slot15: got %h want 7", window_out[63:60]); end
    n_tests++; if (beat_count !== 16'd1) begin n_fail++; $display("FAIL beat1_count: got %0d want 1", beat_count); end
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 10) begin n_fail++; $display("FAIL beat_period: got %0d want 10", c); end
    n_tests++; if (window_out[63:56] !== 8'h97) begin n_fail++; $display("FAIL beat2_slots: got %h want 97", window_out[63:56]); end
    n_tests++; if (rom_addr !== 10'h202) begin n_fail++; $display("FAIL beat2_rom_addr: got %h want 202", rom_addr); end
    @(negedge clk);
    n_tests++; if (beat !== 1'b0) begin n_fail++; $display("FAIL beat_width: got %b want 0", beat); end
    apply_reset();
  endtask

  task automatic test_song_end();
    int c;
    int seen;
    do_start(2'd1, 26'd5);
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 7) begin n_fail++; $display("FAIL end_first_beat: got %0d want 7", c); end
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 5) begin n_fail++; $display("FAIL end_period: got %0d want 5", c); end
    wait_beat(1'b0, 40, c);
    wait_beat(1'b0, 40, c);
    n_tests++; if (window_out[63:48] !== 16'hF321) begin n_fail++; $display("FAIL beat4_slots: got %h want F321", window_out[63:48]); end
    n_tests++; if (rom_addr !== 10'h103) begin n_fail++; $display("FAIL end_addr_frozen: got %h want 103", rom_addr); end
    for (int b = 5; b <= 18; b++) wait_beat(1'b0, 40, c);
    n_tests++; if ({song_done, window_out[7:4]} !== 5'b0_1111) begin n_fail++; $display("FAIL beat18_state: got %b want 01111", {song_done, window_out[7:4]}); end
    wait_beat(1'b0, 40, c);
    n_tests++; if ({song_done, busy} !== 2'b10) begin n_fail++; $display("FAIL done_flags: got %b want 10", {song_done, busy}); end
    n_tests++; if (beat_count !== 16'd19) begin n_fail++; $display("FAIL done_beat_count: got %0d want 19", beat_count); end
    n_tests++; if (window_out !== 64'hF) begin n_fail++; $display("FAIL done_window: got %h want f", window_out); end
    seen = 0;
    repeat (30) begin @(negedge clk); if (beat) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL done_no_beats: got %0d want 0", seen); end
    n_tests++; if ({song_done, window_out} !== {1'b1, 64'hF}) begin n_fail++; $display("FAIL done_hold: got %b %h", song_done, window_out); end
    do_start(2'd1, 26'd5);
    n_tests++; if (window_out !== 64'h0) begin n_fail++; $display("FAIL restart_window: got %h want 0", window_out); end
    n_tests++; if ({busy, song_done, beat_count} !== {2'b10, 16'h0}) begin n_fail++; $display("FAIL restart_flags: got %b %0d", {busy, song_done}, beat_count); end
    apply_reset();
  endtask

  task automatic test_tempo_clamp();
    int c;
    do_start(2'd2, 26'd1);
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 6) begin n_fail++; $display("FAIL clamp1_first: got %0d want 6", c); end
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 4) begin n_fail++; $display("FAIL clamp1_period: got %0d want 4", c); end
    apply_reset();
    do_start(2'd2, 26'd0);
    wait_beat(1'b0, 40, c);
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 4) begin n_fail++; $display("FAIL clamp0_period: got %0d want 4", c); end
    apply_reset();
  endtask

  task automatic test_pause();
    int c;
    int seen;
    logic [63:0] snap;
    do_start(2'd2, 26'd8);
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 10) begin n_fail++; $display("FAIL pause_first_beat: got %0d want 10", c); end
    repeat (3) @(negedge clk);
    snap = window_out;
    pause = 1'b1;
    seen = 0;
    repeat (7) begin @(negedge clk); if (beat || window_out !== snap) seen++; end
    pause = 1'b0;
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL pause_frozen: got %0d changes want 0", seen); end
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 5) begin n_fail++; $display("FAIL pause_delay: got %0d want 5 after release", c); end
    n_tests++; if ({beat_count, window_out[63:60]} !== {16'd2, 4'h9}) begin n_fail++; $display("FAIL pause_resume: got %0d %h want 2 9", beat_count, window_out[63:60]); end
    apply_reset();
  endtask

  task automatic test_start_pause();
    int c;
    int seen;
    @(negedge clk);
    song_sel = 2'd2; tempo_cycles = 26'd4; start = 1'b1; pause = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if ({busy, rom_addr} !== {1'b1, 10'h200}) begin n_fail++; $display("FAIL start_wins: got %b %h want 1 200", busy, rom_addr); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (beat) seen++; end
    n_tests++; if (seen !== 0 || window_out !== 64'h0) begin n_fail++; $display("FAIL paused_play: got %0d beats window %h", seen, window_out); end
    pause = 1'b0;
    wait_beat(1'b0, 40, c);
    n_tests++; if (c !== 4) begin n_fail++; $display("FAIL unpause_beat: got %0d want 4", c); end
    n_tests++; if (window_out[63:60] !== 4'h7) begin n_fail++; $display("FAIL unpause_slot15: got %h want 7", window_out[63:60]); end
    apply_reset();
  endtask

  task automatic test_overflow();
    int c;
    do_start(2'd3, 26'd4);
    n_tests++; if (rom_addr2 !== 5'h18) begin n_fail++; $display("FAIL ovf_start_addr: got %h want 18", rom_addr2); end
    for (int b = 1; b <= 8; b++) begin
      wait_beat(1'b1, 40, c);
      n_tests++; if (rom_addr2[4:3] !== 2'b11) begin n_fail++; $display("FAIL ovf_song_bits: got %b want 11", rom_addr2[4:3]); end
    end
    n_tests++; if (rom_addr2 !== 5'h1F) begin n_fail++; $display("FAIL ovf_addr_beat8: got %h want 1f", rom_addr2); end
    n_tests++; if (window2[15:8] !== 8'h87) begin n_fail++; $display("FAIL ovf_slots_beat8: got %h want 87", window2[15:8]); end
    wait_beat(1'b1, 40, c);
    n_tests++; if ({window2[15:12], rom_addr2, busy2} !== {4'hF, 5'h1F, 1'b1}) begin n_fail++; $display("FAIL ovf_forced_end: got %h %h %b", window2[15:12], rom_addr2, busy2); end
    for (int b = 10; b <= 12; b++) wait_beat(1'b1, 40, c);
    n_tests++; if ({song_done2, busy2, beat_count2} !== {2'b10, 16'd12}) begin n_fail++; $display("FAIL ovf_done: got %b %0d want 10 12", {song_done2, busy2}, beat_count2); end
    n_tests++; if (window2 !== 16'h000F) begin n_fail++; $display("FAIL ovf_window: got %h want 000f", window2); end
    apply_reset();
  endtask

  task automatic test_reset_drain();
    int c;
    int seen;
    do_start(2'd1, 26'd4);
    for (int b = 1; b <= 6; b++) wait_beat(1'b0, 40, c);
    n_tests++; if ({busy, window_out[63:52]} !== {1'b1, 12'h00F}) begin n_fail++; $display("FAIL drain_state: got %b %h want 1 00f", busy, window_out[63:52]); end
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (window_out !== 64'h0) begin n_fail++; $display("FAIL rst_drain_window: got %h want 0", window_out); end
    n_tests++; if ({busy, beat, song_done, beat_count, rom_addr} !== {3'b000, 16'h0, 10'h0}) begin n_fail++; $display("FAIL rst_drain_regs: got %b %0d %h", {busy, beat, song_done}, beat_count, rom_addr); end
    reset = 1'b0;
    seen = 0;
    repeat (15) begin @(negedge clk); if (beat || busy) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rst_drain_idle: got %0d active cycles want 0", seen); end
  endtask

`ifdef SCORE_LOOP_EN
  task automatic test_loop();
    int c;
    logic [3:0] exp_slot [4];
    logic [7:0] exp_loops [4];
    exp_slot[0] = 4'h1; exp_slot[1] = 4'h0; exp_slot[2] = 4'h1; exp_slot[3] = 4'h0;
    exp_loops[0] = 8'd0; exp_loops[1] = 8'd1; exp_loops[2] = 8'd1; exp_loops[3] = 8'd2;
    loop = 1'b1;
    do_start(2'd0, 26'd4);
    for (int b = 0; b < 4; b++) begin
      wait_beat(1'b0, 40, c);
      n_tests++; if ({window_out[63:60], loop_count, busy} !== {exp_slot[b], exp_loops[b], 1'b1}) begin n_fail++; $display("FAIL loop_beat%0d: got %h %0d %b", b + 1, window_out[63:60], loop_count, busy); end
    end
    loop = 1'b0;
    apply_reset();
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem1[i] = 4'h0;
    for (int i = 0; i < 32; i++) mem2[i] = 4'h0;
    mem1[10'h000] = 4'h1; mem1[10'h001] = 4'hF;
    mem1[10'h100] = 4'h1; mem1[10'h101] = 4'h2; mem1[10'h102] = 4'h3; mem1[10'h103] = 4'hF;
    mem1[10'h200] = 4'h7; mem1[10'h201] = 4'h9; mem1[10'h202] = 4'h3;
    for (int i = 0; i < 8; i++) mem2[24 + i] = 4'(i + 1);
`ifdef SCORE_LOOP_EN
    loop = 1'b0;
`endif
    test_reset();
    test_start();
    test_song_end();
    test_tempo_clamp();
    test_pause();
    test_start_pause();
    test_overflow();
    test_reset_drain();
`ifdef SCORE_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
